// File: rtl/ddr_tx_gearbox_if.sv
// rtl/ddr_tx_gearbox_if.sv - 32-bit word stream carrying payload into the DDR TX gearbox
interface ddr_tx_gearbox_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/ddr_tx_gearbox.sv
// rtl/ddr_tx_gearbox.sv - word FIFO and byte-pair gearbox feeding the DDR output sampler; SYNC_WORD_EN adds a sync cycle ahead of each frame
module ddr_tx_gearbox #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter logic [7:0] SYNC_B0   = 8'hBC,
  parameter logic [7:0] SYNC_B1   = 8'h3C
) (
  input  logic             clk,
  input  logic             rst,
  ddr_tx_gearbox_if.slave  stream,
  input  logic             clr_err,
  output logic [7:0]       data_1,
  output logic [7:0]       data_2,
  output logic             tx_active,
  output logic             underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef SYNC_WORD_EN
  typedef enum logic [1:0] {IDLE, SEND, SYNC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  // FIFO entries hold {last, data}
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          wr_en;
  logic          pop;
  logic          fifo_empty;
  logic [32:0]   head;

  state_t        state;
  state_t        state_d;
  logic          phase;
  logic          phase_d;
  logic [31:0]   word;
  logic          word_last;
  logic [7:0]    data_1_d;
  logic [7:0]    data_2_d;
  logic          tx_d;
  logic          ur_set;

  assign wr_en      = stream.s_valid && stream.s_ready;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // Occupancy after this cycle's write and pop; a simultaneous pair leaves it unchanged
  always_comb begin
    count_d = count;
    if (wr_en && !pop) begin
      count_d = count + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count - 1'b1;
    end
  end

  // FIFO storage; entries need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {stream.s_last, stream.s_data};
    end
  end

  // Pointers, count and registered ready; a full FIFO stays closed on the cycle it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      stream.s_ready <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count          <= count_d;
      stream.s_ready <= (count_d < FULL);
    end
  end

  // Next state, pop decision and the lane values for the following cycle
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    pop      = 1'b0;
    data_1_d = IDLE_BYTE;
    data_2_d = IDLE_BYTE;
    tx_d     = 1'b0;
    ur_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          phase_d  = 1'b0;
`ifdef SYNC_WORD_EN
          state_d  = SYNC;
          data_1_d = SYNC_B0;
          data_2_d = SYNC_B1;
`else
          state_d  = SEND;
          data_1_d = head[7:0];
          data_2_d = head[15:8];
          tx_d     = 1'b1;
`endif
        end
      end
`ifdef SYNC_WORD_EN
      SYNC: begin
        state_d  = SEND;
        phase_d  = 1'b0;
        data_1_d = word[7:0];
        data_2_d = word[15:8];
        tx_d     = 1'b1;
      end
`endif
      SEND: begin
        if (!phase) begin
          phase_d  = 1'b1;
          data_1_d = word[23:16];
          data_2_d = word[31:24];
          tx_d     = 1'b1;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          phase_d  = 1'b0;
          data_1_d = head[7:0];
          data_2_d = head[15:8];
          tx_d     = 1'b1;
`ifdef SYNC_WORD_EN
          if (word_last) begin
            state_d  = SYNC;
            data_1_d = SYNC_B0;
            data_2_d = SYNC_B1;
            tx_d     = 1'b0;
          end
`endif
        end else begin
          // Starved: a word without last means the frame was cut short
          state_d = IDLE;
          phase_d = 1'b0;
          ur_set  = !word_last;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 1'b0;
      end
    endcase
  end

  // State, word register, registered lanes and sticky underrun (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      word      <= '0;
      word_last <= 1'b0;
      data_1    <= IDLE_BYTE;
      data_2    <= IDLE_BYTE;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      if (pop) begin
        word      <= head[31:0];
        word_last <= head[32];
      end
      data_1    <= data_1_d;
      data_2    <= data_2_d;
      tx_active <= tx_d;
      if (ur_set) begin
        underrun <= 1'b1;
      end else if (clr_err) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// tb/tb_ddr_tx_gearbox.sv - self-checking bench for ddr_tx_gearbox against a byte-stream reference model
module tb_ddr_tx_gearbox;
  localparam int DEPTH = 4;
`ifdef SYNC_WORD_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] data_1;
  logic [7:0] data_2;
  logic       tx_active;
  logic       underrun;

  int total = 0;
  int bad = 0;

  ddr_tx_gearbox_if bus();

  ddr_tx_gearbox #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .stream   (bus.slave),
    .clr_err  (clr_err),
    .data_1   (data_1),
    .data_2   (data_2),
    .tx_active(tx_active),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Observed byte stream (data_1 then data_2 each payload cycle) and idle-gap positions
  logic [7:0] obs_b[$];
  int         gap_q[$];
  int         run = 0;
  int         last_run = 0;
  logic       prev_tx = 1'b0;
  bit         saw_full;

  always @(negedge clk) begin
    if (!rst && tx_active) begin
      obs_b.push_back(data_1);
      obs_b.push_back(data_2);
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (!rst && prev_tx && !tx_active) gap_q.push_back(obs_b.size());
    prev_tx = tx_active;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'h0, got}, {31'h0, exp});
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e1, input logic [7:0] e2, input logic etx);
    chk({tag, "_data_1"}, {24'h0, data_1}, {24'h0, e1});
    chk({tag, "_data_2"}, {24'h0, data_2}, {24'h0, e2});
    chk1({tag, "_tx_active"}, tx_active, etx);
  endtask

  task automatic clr_obs();
    obs_b.delete();
    gap_q.delete();
  endtask

  // Reference: every accepted word contributes its four bytes, lowest first
  task automatic chk_stream(input string tag, input logic [31:0] words[$]);
    logic [7:0] exp_b[$];
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) exp_b.push_back(8'(words[i] >> (8 * k)));
    end
    chk({tag, "_len"}, 32'(obs_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs_b[i]}, {24'h0, exp_b[i]});
      if (obs_b[i] !== exp_b[i]) break;
    end
  endtask

  // Holds s_valid high and feeds the words in order; last is set on the final word
  task automatic send_burst(input logic [31:0] words[$]);
    int n = 0;
    int cyc = 0;
    bit acc;
    saw_full = 1'b0;
    while (n < words.size() && cyc < 400) begin
      bus.s_valid = 1'b1;
      bus.s_data  = words[n];
      bus.s_last  = (n == words.size() - 1);
      acc = bus.s_ready;
      if (!acc) saw_full = 1'b1;
      tick();
      if (acc) n++;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("burst_accept_all", 32'(n), 32'(words.size()));
  endtask

  initial begin
    logic [31:0] w[$];
    bit          lst[$];
    logic [31:0] d;
    bit          l;
    int          cyc;
    int          b;
    logic        exp_ur;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_s_ready", bus.s_ready, 1'b0);
    chk_out("rst", 8'h00, 8'h00, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    rst = 1'b0;
    tick();
    chk1("s_ready_after_rst", bus.s_ready, 1'b1);
    chk_out("idle_after_rst", 8'h00, 8'h00, 1'b0);

    // single word latency
    clr_obs();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h44332211;
    bus.s_last  = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    chk_out("single_n1", 8'h00, 8'h00, 1'b0);
`ifdef SYNC_WORD_EN
    tick();
    chk_out("single_sync", 8'hBC, 8'h3C, 1'b0);
`endif
    tick();
    chk_out("single_b01", 8'h11, 8'h22, 1'b1);
    tick();
    chk_out("single_b23", 8'h33, 8'h44, 1'b1);
    tick();
    chk_out("single_idle", 8'h00, 8'h00, 1'b0);
    chk1("single_underrun", underrun, 1'b0);

    // sustained burst: FIFO fills, output never gaps
    clr_obs();
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back($urandom());
    send_burst(w);
    repeat (30) tick();
    chk1("burst_ready_dropped", saw_full, 1'b1);
    chk("burst_run_len", 32'(last_run), 32'd20);
    chk_stream("burst", w);
    chk1("burst_underrun", underrun, 1'b0);

    // mid-frame starvation, stickiness and clear
    clr_obs();
    w.delete();
    w.push_back($urandom());
    w.push_back($urandom());
    bus.s_valid = 1'b1;
    bus.s_data  = w[0];
    bus.s_last  = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    repeat (4 + SL) tick();
    chk1("starve_underrun", underrun, 1'b1);
    chk1("starve_idle_tx", tx_active, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = w[1];
    bus.s_last  = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    repeat (8) tick();
    chk1("underrun_sticky", underrun, 1'b1);
    chk_stream("starve", w);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("underrun_cleared", underrun, 1'b0);

    // set and clear in the same cycle: set wins
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom();
    bus.s_last  = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    repeat (2 + SL) tick();
    chk1("setclr_phase1_tx", tx_active, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("setclr_set_wins", underrun, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("setclr_cleared", underrun, 1'b0);

    // reset in phase 1 of the second word while more words are buffered
    repeat (4) tick();
    clr_obs();
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back($urandom());
    send_burst(w);
    cyc = 0;
    while (!(tx_active && obs_b.size() == 6) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk1("rstmid_reached_phase1", (cyc < 50), 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rstmid_idle", 8'h00, 8'h00, 1'b0);
    clr_obs();
    repeat (15) tick();
    chk("rstmid_flushed", 32'(obs_b.size()), 32'd0);
    chk1("rstmid_ready", bus.s_ready, 1'b1);

`ifdef SYNC_WORD_EN
    // two single-word frames back to back, each preceded by a sync cycle
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA4A3A2A1;
    bus.s_last  = 1'b1;
    tick();
    bus.s_data  = 32'hB4B3B2B1;
    tick();
    bus.s_valid = 1'b0;
    chk_out("sync_f1", 8'hBC, 8'h3C, 1'b0);
    tick();
    chk_out("sync_f1_lo", 8'hA1, 8'hA2, 1'b1);
    tick();
    chk_out("sync_f1_hi", 8'hA3, 8'hA4, 1'b1);
    tick();
    chk_out("sync_f2", 8'hBC, 8'h3C, 1'b0);
    tick();
    chk_out("sync_f2_lo", 8'hB1, 8'hB2, 1'b1);
    tick();
    chk_out("sync_f2_hi", 8'hB3, 8'hB4, 1'b1);
    tick();
    chk_out("sync_idle", 8'h00, 8'h00, 1'b0);
`endif

    // randomized traffic against the byte-stream and underrun model
    repeat (4) tick();
    clr_obs();
    w.delete();
    lst.delete();
    for (int k = 0; k < 40; k++) begin
      d = $urandom();
      l = ($urandom_range(0, 2) == 0);
      w.push_back(d);
      lst.push_back(l);
      repeat ($urandom_range(0, 3)) tick();
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      cyc = 0;
      while (!bus.s_ready && cyc < 100) begin
        tick();
        cyc++;
      end
      tick();
      bus.s_valid = 1'b0;
    end
    repeat (40) tick();
    chk_stream("random", w);
    exp_ur = 1'b0;
    foreach (gap_q[i]) begin
      b = gap_q[i];
      chk($sformatf("random_gap%0d_word_aligned", i), 32'(b % 4), 32'd0);
      if (b >= 4 && !lst[b / 4 - 1]) exp_ur = 1'b1;
    end
    chk1("random_underrun", underrun, exp_ur);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
